lsu_ctrl: RTL and testbench

- Parametrised, handshaked load/store unit sitting between the execute stage and the data-memory port.
- Computes the effective address as base + sign-extended immediate and generates byte enables and lane-aligned store data.
- Issues one memory transaction per instruction and returns sign- or zero-extended load data.
- Flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 12 +
 rtl/lsu_align.sv | 33 +++
 rtl/lsu_ctrl.sv | 96 +++++++++
 tb/tb_lsu_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 width codes, FSM states and the alignment helper shared by the load/store unit
package lsu_pkg;
  localparam logic [1:0] LSU_B = 2'd0;
  localparam logic [1:0] LSU_H = 2'd1;
  localparam logic [1:0] LSU_W = 2'd2;
  localparam logic [1:0] LSU_D = 2'd3;
  localparam int LSU_UNS = 2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;
  function automatic logic lsu_misaligned(input logic [2:0] addr_lo, input logic [1:0] size_log2);
    return |(addr_lo & ((3'd1 << size_log2) - 3'd1));
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane shift and load lane extract/extend for one access
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]   i_off,
  input  logic [1:0]      i_size,
  input  logic            i_uns,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [NB-1:0]   o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);
  logic [NB-1:0]   w_bmask;
  logic [XLEN-1:0] w_dmask;
  logic [XLEN-1:0] w_rsh;
  logic            w_sign;
  assign w_bmask = NB'((32'd1 << (32'd1 << i_size)) - 32'd1);
  for (genvar i = 0; i < NB; i++) begin : g_mask
    assign w_dmask[8*i +: 8] = {8{w_bmask[i]}};
  end
  always_comb begin
    o_be    = w_bmask << i_off;
    o_wdata = (i_wdata & w_dmask) << {i_off, 3'b000};
    w_rsh   = i_rdata >> {i_off, 3'b000};
    w_sign  = i_size == LSU_B ? w_rsh[7] : i_size == LSU_H ? w_rsh[15] : i_size == LSU_W ? w_rsh[31] : w_rsh[XLEN-1];
    o_rdata = (w_rsh & w_dmask) | (i_uns ? '0 : ~w_dmask & {XLEN{w_sign}});
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: handshaked load/store FSM issuing one memory transaction per instruction
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [IMM_W-1:0]  req_imm,
  input  logic [XLEN-1:0]   req_base,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  lsu_state_e      r_state, w_next;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [2:0]      r_f3;
  logic            r_store, r_err;
  logic [XLEN-1:0] w_addr, w_wdata_al, w_rdata_ext;
  logic [NB-1:0]   w_be;
  logic            w_accept, w_err;
  assign w_addr   = req_base + {{(XLEN-IMM_W){req_imm[IMM_W-1]}}, req_imm};
  assign w_accept = req_valid && req_ready;
  assign w_err    = lsu_misaligned(w_addr[2:0], req_funct3[1:0]) || (XLEN == 32 && req_funct3[1:0] == LSU_D) ||
                    (req_store && req_funct3[LSU_UNS]) || req_funct3 == 3'b111;
  lsu_align #(.XLEN(XLEN)) u_align (
    .i_off   (r_addr[OW-1:0]),
    .i_size  (r_f3[1:0]),
    .i_uns   (r_f3[LSU_UNS]),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata_al),
    .o_rdata (w_rdata_ext)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // r_rdata is cleared on accept so stores and errors respond with zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_f3    <= '0;
      r_store <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= w_addr;
      r_wdata <= req_wdata;
      r_rdata <= '0;
      r_f3    <= req_funct3;
      r_store <= req_store;
      r_err   <= w_err;
    end else if (r_state == WAIT && mem_rvalid) begin
      r_rdata <= w_rdata_ext;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_err ? RESP : REQ;
      REQ:     if (mem_gnt) w_next = r_store ? RESP : WAIT;
      WAIT:    if (mem_rvalid) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready = r_state == IDLE;
    mem_req   = r_state == REQ;
    mem_we    = mem_req && r_store;
    mem_addr  = mem_req ? r_addr : '0;
    mem_be    = mem_req ? w_be : '0;
    mem_wdata = mem_we ? w_wdata_al : '0;
    rsp_valid = r_state == RESP;
    rsp_data  = rsp_valid ? r_rdata : '0;
    rsp_err   = rsp_valid && r_err;
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and random load/store checks of XLEN=32 and XLEN=64 units against a byte-level model
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x64 = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_imm = '0;
  logic [63:0] req_base = '0, req_wdata = '0, mem_rdata = '0;
  logic        v32, rdy32, mreq32, we32, rv32, er32;
  logic [31:0] addr32, wd32, rd32;
  logic [3:0]  be32;
  logic        v64, rdy64, mreq64, we64, rv64, er64;
  logic [63:0] addr64, wd64, rd64;
  logic [7:0]  be64;
  logic [63:0] o_ready, o_req, o_we, o_addr, o_be, o_wdata, o_rv, o_rdata, o_err;
  int          checks = 0, errors = 0;
  logic [63:0] last_rsp;

  always #5 clk = ~clk;

  assign v32 = req_valid & ~x64;
  assign v64 = req_valid & x64;
  assign o_ready = 64'(x64 ? rdy64 : rdy32);
  assign o_req   = 64'(x64 ? mreq64 : mreq32);
  assign o_we    = 64'(x64 ? we64 : we32);
  assign o_rv    = 64'(x64 ? rv64 : rv32);
  assign o_err   = 64'(x64 ? er64 : er32);
  assign o_addr  = x64 ? addr64 : {32'b0, addr32};
  assign o_be    = x64 ? {56'b0, be64} : {60'b0, be32};
  assign o_wdata = x64 ? wd64 : {32'b0, wd32};
  assign o_rdata = x64 ? rd64 : {32'b0, rd32};

  lsu_ctrl #(.XLEN(32), .IMM_W(12)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(rdy32), .req_store(req_store),
    .req_funct3(req_funct3), .req_imm(req_imm), .req_base(req_base[31:0]), .req_wdata(req_wdata[31:0]),
    .mem_req(mreq32), .mem_gnt(mem_gnt), .mem_we(we32), .mem_addr(addr32), .mem_be(be32),
    .mem_wdata(wd32), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(rv32), .rsp_data(rd32), .rsp_err(er32));

  lsu_ctrl #(.XLEN(64), .IMM_W(12)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_ready(rdy64), .req_store(req_store),
    .req_funct3(req_funct3), .req_imm(req_imm), .req_base(req_base), .req_wdata(req_wdata),
    .mem_req(mreq64), .mem_gnt(mem_gnt), .mem_we(we64), .mem_addr(addr64), .mem_be(be64),
    .mem_wdata(wd64), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rv64), .rsp_data(rd64), .rsp_err(er64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-lane view of one access: which bytes move where, and how a load result is extended
  task automatic model(input bit st, input logic [2:0] f3, input logic [11:0] imm, input logic [63:0] base,
                       input logic [63:0] wd, input logic [63:0] rd,
                       output logic [63:0] ea, output logic [63:0] ebe, output logic [63:0] ewd,
                       output logic [63:0] erd, output bit eerr);
    int nb, sz, off;
    logic [63:0] v;
    nb = x64 ? 8 : 4;
    sz = 1 << f3[1:0];
    ea = base + {{52{imm[11]}}, imm};
    if (!x64) ea[63:32] = '0;
    off = int'(ea % 64'(nb));
    eerr = (ea % 64'(sz) != 0) || (sz == 8 && !x64) || (st && f3[2]) || f3 == 3'b111;
    ebe = '0;
    ewd = '0;
    v = '0;
    for (int k = 0; k < sz; k++)
      if (off + k < nb) begin
        ebe[off+k] = 1'b1;
        ewd[8*(off+k) +: 8] = wd[8*k +: 8];
        v[8*k +: 8] = rd[8*(off+k) +: 8];
      end
    if (!f3[2] && v[8*sz-1])
      for (int k = sz; k < nb; k++) v[8*k +: 8] = 8'hFF;
    erd = v;
  endtask

  task automatic run_op(input bit st, input logic [2:0] f3, input logic [11:0] imm, input logic [63:0] base,
                        input logic [63:0] wd, input logic [63:0] rd, input int gd, input int rvd);
    logic [63:0] ea, ebe, ewd, erd;
    bit eerr;
    model(st, f3, imm, base, wd, rd, ea, ebe, ewd, erd, eerr);
    @(negedge clk);
    chk("ready_idle", o_ready, 64'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_imm = imm; req_base = base; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_base = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    if (eerr) begin
      chk("err_valid", o_rv, 64'd1);
      chk("err_flag", o_err, 64'd1);
      chk("err_data", o_rdata, 64'd0);
      chk("err_noreq", o_req, 64'd0);
      last_rsp = o_rdata;
    end else begin
      for (int c = 0; c <= gd; c++) begin
        chk("mem_req", o_req, 64'd1);
        chk("mem_addr", o_addr, ea);
        chk("mem_be", o_be, ebe);
        chk("mem_we", o_we, 64'(st));
        if (st) chk("mem_wdata", o_wdata, ewd);
        chk("busy", o_ready, 64'd0);
        chk("no_rsp", o_rv, 64'd0);
        if (c == gd) begin
          mem_gnt = 1'b1;
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata = {$urandom, $urandom};
        end
        @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!st) begin
        chk("req_drop", o_req, 64'd0);
        for (int c = 0; c < rvd; c++) begin
          chk("wait_rsp", o_rv, 64'd0);
          @(negedge clk);
        end
        chk("wait_rsp", o_rv, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
      end
      chk("rsp_valid", o_rv, 64'd1);
      chk("rsp_err", o_err, 64'd0);
      chk("rsp_data", o_rdata, st ? 64'd0 : erd);
      chk("rsp_noreq", o_req, 64'd0);
      last_rsp = o_rdata;
    end
    @(negedge clk);
    chk("rsp_pulse", o_rv, 64'd0);
    chk("ready_back", o_ready, 64'd1);
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [11:0] imm;
    logic [63:0] base;
    repeat (2) @(negedge clk);
    for (int x = 0; x < 2; x++) begin
      x64 = 1'(x);
      #1;
      chk("rst_ready", o_ready, 64'd1);
      chk("rst_req", o_req, 64'd0);
      chk("rst_we", o_we, 64'd0);
      chk("rst_addr", o_addr, 64'd0);
      chk("rst_be", o_be, 64'd0);
      chk("rst_wdata", o_wdata, 64'd0);
      chk("rst_rv", o_rv, 64'd0);
      chk("rst_data", o_rdata, 64'd0);
      chk("rst_err", o_err, 64'd0);
    end
    x64 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 3'b000, 12'h003, 64'h1000, 64'hAABBCCDD, 64'h0, 0, 0);
    run_op(1'b0, 3'b001, 12'hFFE, 64'h2000, 64'h0, 64'h80011234, 0, 0);
    chk("lh_lit", last_rsp, 64'hFFFF8001);
    run_op(1'b0, 3'b101, 12'hFFE, 64'h2000, 64'h0, 64'h80011234, 1, 2);
    chk("lhu_lit", last_rsp, 64'h00008001);
    run_op(1'b0, 3'b010, 12'h002, 64'h1000, 64'h0, 64'h12345678, 0, 0);
    run_op(1'b1, 3'b010, 12'h010, 64'h4000, 64'hCAFEF00D, 64'h0, 5, 0);
    run_op(1'b0, 3'b011, 12'h008, 64'h0, 64'h0, 64'h1, 0, 0);
    run_op(1'b1, 3'b100, 12'h000, 64'h100, 64'h55, 64'h0, 0, 0);
    run_op(1'b0, 3'b111, 12'h000, 64'h100, 64'h0, 64'h0, 0, 0);
    // abort a load while waiting for data; the late rvalid must be dropped
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_imm = 12'h0; req_base = 64'h3000;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("wait_entered", o_req, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_req", o_req, 64'd0);
    chk("abort_ready", o_ready, 64'd1);
    chk("abort_rv", o_rv, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("late_rv_ignored", o_rv, 64'd0);
      chk("late_ready", o_ready, 64'd1);
      @(negedge clk);
    end
    run_op(1'b0, 3'b010, 12'h004, 64'h3000, 64'h0, 64'h7654_3210, 0, 1);
    chk("lw_after_abort", last_rsp, 64'h76543210);
    // abort while a request is stalled; mem_req must drop without a clock edge
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001; req_imm = 12'h2; req_base = 64'h500;
    @(negedge clk);
    req_valid = 1'b0;
    chk("stall_req", o_req, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", o_req, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("stall_abort_ready", o_ready, 64'd1);
    x64 = 1'b1;
    run_op(1'b0, 3'b011, 12'h008, 64'h0, 64'h0, 64'h8000_0000_0000_0001, 0, 0);
    chk("ld_lit", last_rsp, 64'h8000_0000_0000_0001);
    run_op(1'b0, 3'b010, 12'h00C, 64'h0, 64'h0, 64'h8000_0000_0000_0000, 2, 0);
    chk("lw64_lit", last_rsp, 64'hFFFF_FFFF_8000_0000);
    run_op(1'b0, 3'b110, 12'h00C, 64'h0, 64'h0, 64'h8000_0000_0000_0000, 0, 0);
    chk("lwu_lit", last_rsp, 64'h0000_0000_8000_0000);
    run_op(1'b1, 3'b011, 12'hFF8, 64'h10, 64'h0102_0304_0506_0708, 64'h0, 1, 0);
    run_op(1'b0, 3'b011, 12'h004, 64'h10, 64'h0, 64'h0, 0, 0);
    for (int x = 0; x < 2; x++) begin
      x64 = 1'(x);
      for (int n = 0; n < 40; n++) begin
        st = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        base = {$urandom, $urandom};
        imm = 12'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          base[2:0] = 3'b000;
          imm[2:0] = 3'($urandom_range(0, 7)) & ~((3'd1 << f3[1:0]) - 3'd1);
        end
        run_op(st, f3, imm, base, {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
